blitz_hook_ctrl: RTL and testbench



---
 rtl/blitz_hook_ctrl_pkg.sv | 24 ++
 rtl/blitz_hook_ctrl_if.sv | 24 ++
 rtl/blitz_hook_hit.sv | 37 +++
 rtl/blitz_hook_ctrl.sv | 140 ++++++++++++++
 tb/tb_blitz_hook_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/blitz_hook_ctrl_pkg.sv
// blitz_pkg: screen constants and FSM encoding
// shared by the hook controller and its hit test.
package blitz_pkg;

  localparam int SCREEN_W     = 320;
  localparam int SCREEN_H     = 240;
  localparam int ARM_BASE_X   = 42;
  localparam int ARM_Y_OFFSET = 7;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_TICK = 3'd1;
  localparam logic [2:0] ST_PLOT      = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_UPDATE    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_WAIT_TICK = ST_WAIT_TICK,
    S_PLOT      = ST_PLOT,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_UPDATE    = ST_UPDATE
  } state_e;

endpackage

// File: rtl/blitz_hook_ctrl_if.sv
// Plot/done handshake between the hook controller
// (master) and the arm drawer (slave).
interface blitz_hook_ctrl_if;

  logic       arm_plot;
  logic [8:0] arm_x;
  logic [7:0] arm_y;
  logic       arm_done;

  modport master (
    output arm_plot,
    output arm_x,
    output arm_y,
    input  arm_done
  );

  modport slave (
    input  arm_plot,
    input  arm_x,
    input  arm_y,
    output arm_done
  );

endinterface

// File: rtl/blitz_hook_hit.sv
// Combinational catch test of the hook tip against
// the poro box, in 10-bit arithmetic so nothing wraps.
module blitz_hook_hit
  import blitz_pkg::*;
#(
  parameter int PORO_W = 16,
  parameter int PORO_H = 16
) (
  input  logic [8:0] arm_x,
  input  logic [7:0] arm_y,
  input  logic [8:0] poro_x,
  input  logic [7:0] poro_y,
  output logic       hit
);

  logic [9:0] x_tip;
  logic [9:0] x_lo;
  logic [9:0] x_hi;
  logic [9:0] row_top;
  logic [9:0] row_bot;
  logic [9:0] y_lo;
  logic [9:0] y_hi;

  // The drawn arm is two rows thick at arm_y+7 and arm_y+8.
  always_comb begin
    x_tip   = {1'b0, arm_x};
    x_lo    = {1'b0, poro_x};
    x_hi    = x_lo + 10'(PORO_W - 1);
    row_top = {2'b00, arm_y} + 10'(ARM_Y_OFFSET);
    row_bot = row_top + 10'd1;
    y_lo    = {2'b00, poro_y};
    y_hi    = y_lo + 10'(PORO_H - 1);
    hit     = (x_tip >= x_lo) && (x_tip <= x_hi) &&
              (row_top <= y_hi) && (row_bot >= y_lo);
  end

endmodule

// File: rtl/blitz_hook_ctrl.sv
// Blitzcrank grab animation: paces the hook tip out and
// back one step per frame and reports catches.
module blitz_hook_ctrl
  import blitz_pkg::*;
#(
  parameter int ARM_BASE_X = 42,
  parameter int ARM_MAX_X  = 298,
  parameter int STEP       = 8,
  parameter int PORO_W     = 16,
  parameter int PORO_H     = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      fire,
  input  logic                      frame_tick,
  input  logic [7:0]                blitz_y,
  input  logic [8:0]                poro_x,
  input  logic [7:0]                poro_y,
  blitz_hook_ctrl_if.master         drw,
  output logic                      busy,
  output logic                      hooked,
  output logic                      caught,
  output logic [8:0]                pull_x,
  output logic                      hook_done
);

  localparam logic [9:0] BASE10 = 10'(ARM_BASE_X);
  localparam logic [9:0] MAX10  = 10'(ARM_MAX_X);
  localparam logic [9:0] STEP10 = 10'(STEP);

  state_e     state_q, state_d;
  logic [8:0] arm_x_q, arm_x_d;
  logic [7:0] arm_y_q, arm_y_d;
  logic       dir_q, dir_d;
  logic       hooked_q, hooked_d;
  logic       caught_q, caught_d;
  logic       done_q, done_d;

  logic       hit;
  logic [9:0] x_cur;
  logic [9:0] x_up;
  logic [9:0] x_dn;

  blitz_hook_hit #(
    .PORO_W (PORO_W),
    .PORO_H (PORO_H)
  ) u_hit (
    .arm_x  (arm_x_q),
    .arm_y  (arm_y_q),
    .poro_x (poro_x),
    .poro_y (poro_y),
    .hit    (hit)
  );

  always_comb begin
    x_cur = {1'b0, arm_x_q};
    x_up  = (x_cur + STEP10 > MAX10) ? MAX10 : x_cur + STEP10;
    x_dn  = (x_cur < BASE10 + STEP10) ? BASE10 : x_cur - STEP10;
  end

  always_comb begin
    state_d  = state_q;
    arm_x_d  = arm_x_q;
    arm_y_d  = arm_y_q;
    dir_d    = dir_q;
    hooked_d = hooked_q;
    caught_d = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fire) begin
          arm_x_d = 9'(BASE10 + STEP10);
          arm_y_d = blitz_y;
          dir_d   = 1'b0;
          state_d = S_WAIT_TICK;
        end
      end
      S_WAIT_TICK: begin
        if (frame_tick) state_d = S_PLOT;
      end
      S_PLOT: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (drw.arm_done) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        state_d = S_WAIT_TICK;
        if (!dir_q && hit) begin
          hooked_d = 1'b1;
          caught_d = 1'b1;
          dir_d    = 1'b1;
          arm_x_d  = x_dn[8:0];
        end else if (!dir_q && x_cur >= MAX10) begin
          dir_d   = 1'b1;
          arm_x_d = x_dn[8:0];
        end else if (!dir_q) begin
          arm_x_d = x_up[8:0];
        end else if (x_cur == BASE10) begin
          hooked_d = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          arm_x_d = x_dn[8:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      arm_x_q  <= 9'(BASE10);
      arm_y_q  <= 8'd0;
      dir_q    <= 1'b0;
      hooked_q <= 1'b0;
      caught_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      arm_x_q  <= arm_x_d;
      arm_y_q  <= arm_y_d;
      dir_q    <= dir_d;
      hooked_q <= hooked_d;
      caught_q <= caught_d;
      done_q   <= done_d;
    end
  end

  assign drw.arm_plot = (state_q == S_PLOT);
  assign drw.arm_x    = arm_x_q;
  assign drw.arm_y    = arm_y_q;
  assign busy         = (state_q != S_IDLE);
  assign hooked       = hooked_q;
  assign caught       = caught_q;
  assign hook_done    = done_q;
  assign pull_x       = hooked_q ? arm_x_q : 9'd0;

endmodule

// File: tb/tb_blitz_hook_ctrl.sv
// Bench for blitz_hook_ctrl: drawer and frame-tick models,
// table-driven and random grabs against a plot-list model.
module tb_blitz_hook_ctrl;

  localparam int BASE = 42;
  localparam int MAX  = 298;
  localparam int STP  = 8;
  localparam int PW   = 16;
  localparam int PH   = 16;

  typedef struct {
    int px;
    int py;
    int by;
    int per;
    int dly;
    bit hold;
    int plots;
    int caught;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       fire;
  logic       frame_tick;
  logic [7:0] blitz_y;
  logic [8:0] poro_x;
  logic [7:0] poro_y;
  logic       busy;
  logic       hooked;
  logic       caught;
  logic [8:0] pull_x;
  logic       hook_done;

  blitz_hook_ctrl_if u_if ();

  blitz_hook_ctrl #(
    .ARM_BASE_X (BASE),
    .ARM_MAX_X  (MAX),
    .STEP       (STP),
    .PORO_W     (PW),
    .PORO_H     (PH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .fire       (fire),
    .frame_tick (frame_tick),
    .blitz_y    (blitz_y),
    .poro_x     (poro_x),
    .poro_y     (poro_y),
    .drw        (u_if),
    .busy       (busy),
    .hooked     (hooked),
    .caught     (caught),
    .pull_x     (pull_x),
    .hook_done  (hook_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit tick_en = 1'b0;
  int tick_period = 50;
  int drw_delay = 3;
  int plot_q[$];
  int y_q[$];
  int exp_q[$];
  int x_unstable = 0;
  int plot_in_wait = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected plot positions and 1-based index of the catching plot.
  function automatic int model(input int px, input int py, input int by);
    int x;
    int cidx;
    bit ret;
    exp_q.delete();
    x = BASE + STP;
    ret = 1'b0;
    cidx = 0;
    for (int n = 0; n < 200; n++) begin
      exp_q.push_back(x);
      if (!ret) begin
        if (x >= px && x <= px + PW - 1 &&
            by + 7 <= py + PH - 1 && by + 8 >= py) begin
          cidx = exp_q.size();
          ret = 1'b1;
          x = (x - STP < BASE) ? BASE : x - STP;
        end else if (x >= MAX) begin
          ret = 1'b1;
          x = x - STP;
        end else begin
          x = (x + STP > MAX) ? MAX : x + STP;
        end
      end else begin
        if (x == BASE) break;
        x = (x - STP < BASE) ? BASE : x - STP;
      end
    end
    return cidx;
  endfunction

  initial begin
    int cnt;
    cnt = 0;
    frame_tick = 1'b0;
    forever begin
      @(negedge clk);
      frame_tick = 1'b0;
      if (tick_en) begin
        cnt++;
        if (cnt >= tick_period) begin
          frame_tick = 1'b1;
          cnt = 0;
        end
      end
    end
  end

  initial begin
    logic [8:0] hold_x;
    u_if.arm_done = 1'b0;
    forever begin
      @(negedge clk);
      if (u_if.arm_plot === 1'b1) begin
        plot_q.push_back(int'(u_if.arm_x));
        y_q.push_back(int'(u_if.arm_y));
        hold_x = u_if.arm_x;
        for (int i = 0; i < drw_delay; i++) begin
          @(negedge clk);
          if (u_if.arm_x !== hold_x) x_unstable++;
          if (u_if.arm_plot !== 1'b0) plot_in_wait++;
        end
        u_if.arm_done = 1'b1;
        @(negedge clk);
        u_if.arm_done = 1'b0;
      end
    end
  end

  task automatic run_case(input int px, input int py, input int by,
                          input int per, input int dly, input bit hold,
                          output int nplots, output int ncaught);
    int cidx;
    int caught_at;
    int pull_bad;
    int hk_bad;
    int xbad;
    int ybad;
    bit done_seen;
    cidx = model(px, py, by);
    poro_x = 9'(px);
    poro_y = 8'(py);
    blitz_y = 8'(by);
    tick_period = per;
    drw_delay = dly;
    plot_q.delete();
    y_q.delete();
    x_unstable = 0;
    plot_in_wait = 0;
    pull_bad = 0;
    hk_bad = 0;
    ncaught = 0;
    caught_at = 0;
    done_seen = 1'b0;
    @(negedge clk);
    fire = 1'b1;
    @(negedge clk);
    check("busy_after_fire", busy, 1);
    if (!hold) fire = 1'b0;
    blitz_y = ~8'(by);
    for (int g = 0; g < 20000 && !done_seen; g++) begin
      @(negedge clk);
      if (caught === 1'b1) begin
        ncaught++;
        caught_at = plot_q.size();
      end
      if (pull_x !== (hooked ? u_if.arm_x : 9'd0)) pull_bad++;
      if (hooked !== (ncaught > 0 && hook_done !== 1'b1)) hk_bad++;
      if (hook_done === 1'b1) done_seen = 1'b1;
    end
    check("hook_done_seen", done_seen, 1);
    check("idle_at_done", busy, 0);
    nplots = plot_q.size();
    check("plots_vs_model", nplots, exp_q.size());
    xbad = 0;
    ybad = 0;
    for (int i = 0; i < nplots && i < exp_q.size(); i++) begin
      if (plot_q[i] != exp_q[i]) xbad++;
      if (y_q[i] != by) ybad++;
    end
    check("plot_x_seq", xbad, 0);
    check("plot_y_latched", ybad, 0);
    check("caught_count", ncaught, (cidx > 0) ? 1 : 0);
    check("caught_plot_idx", caught_at, cidx);
    check("x_stable_in_wait", x_unstable, 0);
    check("one_plot_per_frame", plot_in_wait, 0);
    check("pull_x_track", pull_bad, 0);
    check("hooked_level", hk_bad, 0);
    @(negedge clk);
    check("hook_done_pulse", hook_done, 0);
    if (hold) begin
      check("relaunch_after_done", busy, 1);
      resetn = 1'b0;
      fire = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
    end else begin
      check("no_relaunch", busy, 0);
    end
  endtask

  initial begin
    vec_t tbl[9];
    int np;
    int nc;
    int late_bad;
    int g;
    int rby;
    tbl[0] = '{0,   0,   100, 50, 3,   1'b0, 64, 0};
    tbl[1] = '{100, 100, 100, 12, 3,   1'b0, 16, 1};
    tbl[2] = '{100, 109, 100, 12, 3,   1'b0, 64, 0};
    tbl[3] = '{100, 93,  100, 12, 3,   1'b0, 16, 1};
    tbl[4] = '{290, 100, 100, 12, 3,   1'b0, 62, 1};
    tbl[5] = '{299, 100, 100, 12, 3,   1'b0, 64, 0};
    tbl[6] = '{50,  100, 100, 12, 3,   1'b0, 2,  1};
    tbl[7] = '{100, 100, 100, 50, 200, 1'b0, 16, 1};
    tbl[8] = '{100, 100, 100, 12, 3,   1'b1, 16, 1};
    resetn = 1'b0;
    fire = 1'b0;
    blitz_y = 8'd0;
    poro_x = 9'd0;
    poro_y = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_arm_plot", u_if.arm_plot, 0);
    check("rst_busy", busy, 0);
    check("rst_hooked", hooked, 0);
    check("rst_caught", caught, 0);
    check("rst_hook_done", hook_done, 0);
    check("rst_pull_x", pull_x, 0);
    check("rst_arm_x", u_if.arm_x, BASE);
    check("rst_arm_y", u_if.arm_y, 0);
    resetn = 1'b1;
    tick_en = 1'b1;

    foreach (tbl[i]) begin
      run_case(tbl[i].px, tbl[i].py, tbl[i].by, tbl[i].per,
               tbl[i].dly, tbl[i].hold, np, nc);
      check("tbl_plots", np, tbl[i].plots);
      check("tbl_caught", nc, tbl[i].caught);
    end

    for (int r = 0; r < 6; r++) begin
      rby = int'($urandom_range(60, 200));
      run_case(int'($urandom_range(30, 310)),
               rby + int'($urandom_range(0, 24)) - 12,
               rby,
               int'($urandom_range(8, 20)),
               int'($urandom_range(1, 6)),
               1'b0, np, nc);
    end

    drw_delay = 40;
    tick_period = 12;
    poro_x = 9'd100;
    poro_y = 8'd100;
    blitz_y = 8'd100;
    @(negedge clk);
    fire = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    for (g = 0; g < 3000 && hooked !== 1'b1; g++) @(negedge clk);
    check("rst_seq_hooked", hooked, 1);
    for (g = 0; g < 3000 && u_if.arm_plot !== 1'b1; g++) @(negedge clk);
    check("rst_seq_plot", u_if.arm_plot, 1);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_arm_plot", u_if.arm_plot, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hooked", hooked, 0);
    check("mid_rst_caught", caught, 0);
    check("mid_rst_hook_done", hook_done, 0);
    check("mid_rst_pull_x", pull_x, 0);
    check("mid_rst_arm_x", u_if.arm_x, BASE);
    check("mid_rst_arm_y", u_if.arm_y, 0);
    resetn = 1'b1;
    late_bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy !== 1'b0 || u_if.arm_plot !== 1'b0 ||
          hook_done !== 1'b0 || caught !== 1'b0) late_bad++;
    end
    check("late_done_ignored", late_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule
